// File: rtl/pc_debug_unit.sv
// pc_debug_unit
//   Next-PC generator for the MIPS fetch stage. It adds a RUN/HALTED/STEP
//   execution state machine, address breakpoints and an advance counter, all
//   controlled by the UART debug unit.
//
//   Ports
//     clk, i_rst          clock and synchronous active-high reset
//     i_stall             hazard stall; the PC holds while it is high
//     i_exc/_vector       exception redirect (highest priority)
//     i_branch_taken/addr branch redirect
//     i_jump/_addr        jump redirect
//     i_instr_halt        HALT instruction decoded at fetch
//     i_dbg_*_req         debug halt / run / single-step pulses
//     i_bkpt_wr_*         breakpoint register write port
//     o_pc, o_pc_next_seq current PC and PC + PC_INC
//     o_state, o_halted   execution state (00 RUN, 01 HALTED, 10 STEP)
//     o_bkpt_hit          one-cycle pulse after a breakpoint halt
//     o_step_done         one-cycle pulse after a single step completes
//     o_adv_cnt           number of PC advances (wraps at 2^32)
module pc_debug_unit #(
  parameter int               NB_PC        = 32,
  parameter logic [NB_PC-1:0] RESET_ADDR   = '0,
  parameter int               PC_INC       = 4,
  parameter int               N_BKPT       = 4,
  parameter bit               START_HALTED = 1'b1,
  localparam int              NB_IDX       = (N_BKPT > 1) ? $clog2(N_BKPT) : 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_exc,
  input  logic [NB_PC-1:0]  i_exc_vector,
  input  logic              i_branch_taken,
  input  logic [NB_PC-1:0]  i_branch_addr,
  input  logic              i_jump,
  input  logic [NB_PC-1:0]  i_jump_addr,
  input  logic              i_instr_halt,
  input  logic              i_dbg_halt_req,
  input  logic              i_dbg_run_req,
  input  logic              i_dbg_step_req,
  input  logic              i_bkpt_wr_en,
  input  logic [NB_IDX-1:0] i_bkpt_wr_idx,
  input  logic [NB_PC-1:0]  i_bkpt_wr_addr,
  input  logic              i_bkpt_wr_valid,
  output logic [NB_PC-1:0]  o_pc,
  output logic [NB_PC-1:0]  o_pc_next_seq,
  output logic [1:0]        o_state,
  output logic              o_halted,
  output logic              o_bkpt_hit,
  output logic              o_step_done,
  output logic [31:0]       o_adv_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  localparam state_e RST_STATE = START_HALTED ? ST_HALT : ST_RUN;

  state_e                   state_q, state_d;
  logic                     skip_q, skip_d;
  logic                     halted_q;
  logic [NB_PC-1:0]         pc_q, pc_d;
  logic [31:0]              cnt_q;
  logic                     hit_q, hit_d;
  logic                     done_q, done_d;

  logic [N_BKPT-1:0][NB_PC-1:0] bkpt_addr;
  logic [N_BKPT-1:0]            bkpt_vld;
  logic [N_BKPT-1:0]            bkpt_eq;

  logic bkpt_match;
  logic halt_cond;
  logic adv;

  // Breakpoint registers. An index with no matching entry (out of range)
  // simply writes nothing. The compare reads the registered value, so a
  // write to the entry being matched only takes effect next cycle.
  for (genvar g = 0; g < N_BKPT; g++) begin : g_bkpt
    assign bkpt_eq[g] = bkpt_vld[g] && (bkpt_addr[g] == pc_q);

    always_ff @(posedge clk) begin
      if (i_rst) begin
        bkpt_addr[g] <= '0;
        bkpt_vld[g]  <= 1'b0;
      end else if (i_bkpt_wr_en && (i_bkpt_wr_idx == NB_IDX'(g))) begin
        bkpt_addr[g] <= i_bkpt_wr_addr;
        bkpt_vld[g]  <= i_bkpt_wr_valid;
      end
    end
  end

  // Breakpoints only count in RUN, and not on the first RUN cycle after a
  // resume, so continuing from a breakpoint address does not re-trigger.
  assign bkpt_match = (|bkpt_eq) && (state_q == ST_RUN) && !skip_q;
  assign halt_cond  = i_dbg_halt_req || i_instr_halt || bkpt_match;
  assign adv        = ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                      !i_stall && !halt_cond;

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= RST_STATE;
      halted_q <= START_HALTED;
      skip_q   <= 1'b1;
      pc_q     <= RESET_ADDR;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALT);
      skip_q   <= skip_d;
      pc_q     <= pc_d;
      cnt_q    <= adv ? cnt_q + 32'd1 : cnt_q;
      hit_q    <= hit_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    case (state_q)
      ST_RUN: begin
        skip_d = 1'b0;
        if (halt_cond) state_d = ST_HALT;
      end
      ST_HALT: begin
        // Step wins over run when both arrive together.
        if (i_dbg_step_req) begin
          state_d = ST_STEP;
          skip_d  = 1'b1;
        end else if (i_dbg_run_req) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end
      end
      ST_STEP: begin
        if (i_dbg_halt_req || i_instr_halt || !i_stall) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    pc_d   = pc_q;
    hit_d  = 1'b0;
    done_d = 1'b0;
    if (adv) begin
      if (i_exc)               pc_d = i_exc_vector;
      else if (i_branch_taken) pc_d = i_branch_addr;
      else if (i_jump)         pc_d = i_jump_addr;
      else                     pc_d = o_pc_next_seq;
    end
    case (state_q)
      ST_RUN:  hit_d = halt_cond && bkpt_match;
      // A debug halt aborts the step silently; an instruction halt or a
      // completed advance both count as the step finishing.
      ST_STEP: done_d = !i_dbg_halt_req && (i_instr_halt || !i_stall);
      default: ;
    endcase
  end

  assign o_pc          = pc_q;
  assign o_pc_next_seq = pc_q + NB_PC'(PC_INC);
  assign o_state       = state_q;
  assign o_halted      = halted_q;
  assign o_bkpt_hit    = hit_q;
  assign o_step_done   = done_q;
  assign o_adv_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_debug_unit.sv
module tb_pc_debug_unit;

  localparam int NBK = 3;  // non power of two, so index 3 is out of range

  logic        clk = 1'b0;
  logic        rst, stall, exc, br, jmp, ihalt, dhalt, drun, dstep;
  logic        wen, wvalid;
  logic [1:0]  widx;
  logic [31:0] exc_vec, br_addr, jmp_addr, waddr;
  logic [31:0] pc, pc_seq, adv_cnt;
  logic [1:0]  st;
  logic        halted, hit, done;

  logic        rst8;
  logic [7:0]  pc8, pc8_seq;
  logic [1:0]  st8;
  logic        halted8, hit8, done8;
  logic [31:0] cnt8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_debug_unit #(.NB_PC(32), .RESET_ADDR(32'h0), .PC_INC(4), .N_BKPT(NBK),
                  .START_HALTED(1'b1)) dut (
    .clk(clk), .i_rst(rst), .i_stall(stall),
    .i_exc(exc), .i_exc_vector(exc_vec),
    .i_branch_taken(br), .i_branch_addr(br_addr),
    .i_jump(jmp), .i_jump_addr(jmp_addr),
    .i_instr_halt(ihalt), .i_dbg_halt_req(dhalt),
    .i_dbg_run_req(drun), .i_dbg_step_req(dstep),
    .i_bkpt_wr_en(wen), .i_bkpt_wr_idx(widx),
    .i_bkpt_wr_addr(waddr), .i_bkpt_wr_valid(wvalid),
    .o_pc(pc), .o_pc_next_seq(pc_seq), .o_state(st), .o_halted(halted),
    .o_bkpt_hit(hit), .o_step_done(done), .o_adv_cnt(adv_cnt));

  // 8-bit free-running instance for the wrap-around check.
  pc_debug_unit #(.NB_PC(8), .RESET_ADDR(8'hF4), .PC_INC(4), .N_BKPT(1),
                  .START_HALTED(1'b0)) dut8 (
    .clk(clk), .i_rst(rst8), .i_stall(1'b0),
    .i_exc(1'b0), .i_exc_vector(8'h0),
    .i_branch_taken(1'b0), .i_branch_addr(8'h0),
    .i_jump(1'b0), .i_jump_addr(8'h0),
    .i_instr_halt(1'b0), .i_dbg_halt_req(1'b0),
    .i_dbg_run_req(1'b0), .i_dbg_step_req(1'b0),
    .i_bkpt_wr_en(1'b0), .i_bkpt_wr_idx(1'b0),
    .i_bkpt_wr_addr(8'h0), .i_bkpt_wr_valid(1'b0),
    .o_pc(pc8), .o_pc_next_seq(pc8_seq), .o_state(st8), .o_halted(halted8),
    .o_bkpt_hit(hit8), .o_step_done(done8), .o_adv_cnt(cnt8));

  // Reference model, stepped once per clock from the current inputs.
  localparam int MR = 0, MH = 1, MS = 2;
  int          m_st;
  logic [31:0] m_pc, m_cnt;
  bit          m_hit, m_done, m_skip;
  logic [31:0] m_ba [NBK];
  bit          m_bv [NBK];

  task automatic model_step();
    bit match, brk, halt, adv;
    int nst;
    if (rst) begin
      m_pc = 32'h0; m_st = MH; m_cnt = 0; m_hit = 0; m_done = 0; m_skip = 1;
      for (int i = 0; i < NBK; i++) begin m_ba[i] = 0; m_bv[i] = 0; end
      return;
    end
    match = 0;
    for (int i = 0; i < NBK; i++) if (m_bv[i] && m_ba[i] == m_pc) match = 1;
    brk  = (m_st == MR) && match && !m_skip;
    halt = dhalt || ihalt || brk;
    adv  = (m_st != MH) && !stall && !halt;
    nst = m_st; m_hit = 0; m_done = 0;
    if (m_st == MR) begin
      if (halt) begin nst = MH; m_hit = brk; end
      m_skip = 0;
    end else if (m_st == MH) begin
      if (dstep)     begin nst = MS; m_skip = 1; end
      else if (drun) begin nst = MR; m_skip = 1; end
    end else begin
      if (dhalt)       nst = MH;
      else if (ihalt)  begin nst = MH; m_done = 1; end
      else if (!stall) begin nst = MH; m_done = 1; end
    end
    if (adv) begin
      m_pc  = exc ? exc_vec : br ? br_addr : jmp ? jmp_addr : m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
    m_st = nst;
    if (wen && widx < NBK) begin m_ba[widx] = waddr; m_bv[widx] = wvalid; end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; exc = 0; br = 0; jmp = 0; ihalt = 0; dhalt = 0;
    drun = 0; dstep = 0; wen = 0; widx = 0; waddr = 0; wvalid = 0;
    exc_vec = 0; br_addr = 0; jmp_addr = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
    total++; if (st !== 2'b01) begin bad++; $display("FAIL rst_state got=%b exp=01", st); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL rst_halted got=%b exp=1", halted); end
    total++; if (adv_cnt !== 32'h0 || hit !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_misc cnt=%h hit=%b done=%b exp 0/0/0", adv_cnt, hit, done); end
  endtask

  task automatic test_run_free();
    drun = 1; tick(); drun = 0;
    repeat (5) tick();
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL run_pc got=%h exp=14", pc); end
    total++; if (adv_cnt !== 32'd5) begin bad++; $display("FAIL run_cnt got=%0d exp=5", adv_cnt); end
    total++; if (st !== 2'b00) begin bad++; $display("FAIL run_state got=%b exp=00", st); end
  endtask

  task automatic test_priority();
    exc = 1; exc_vec = 32'h80; br = 1; br_addr = 32'h40; jmp = 1; jmp_addr = 32'h20;
    tick();
    total++; if (pc !== 32'h80) begin bad++; $display("FAIL prio_exc got=%h exp=80", pc); end
    exc = 0; tick();
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL prio_br got=%h exp=40", pc); end
    stall = 1; tick();
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL prio_stall got=%h exp=40", pc); end
    stall = 0; br = 0; tick();
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL prio_jmp got=%h exp=20", pc); end
    total++; if (adv_cnt !== 32'd8) begin bad++; $display("FAIL prio_cnt got=%0d exp=8", adv_cnt); end
    idle();
  endtask

  task automatic test_bkpt();
    do_reset();
    wen = 1; widx = 0; waddr = 32'h0C; wvalid = 1; tick(); idle();
    drun = 1; tick(); drun = 0;
    repeat (3) tick();
    total++; if (pc !== 32'h0C || st !== 2'b00) begin
      bad++; $display("FAIL bk_pre pc=%h st=%b exp 0c/00", pc, st); end
    tick();
    total++; if (pc !== 32'h0C || st !== 2'b01) begin
      bad++; $display("FAIL bk_halt pc=%h st=%b exp 0c/01", pc, st); end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL bk_hit got=%b exp=1", hit); end
    tick();
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL bk_hit_pulse got=%b exp=0", hit); end
    drun = 1; tick(); drun = 0;
    tick();
    total++; if (pc !== 32'h10 || st !== 2'b00 || hit !== 1'b0) begin
      bad++; $display("FAIL bk_resume pc=%h st=%b hit=%b exp 10/00/0", pc, st, hit); end
  endtask

  task automatic test_step_stall();
    do_reset();
    drun = 1; tick(); drun = 0;
    repeat (4) tick();
    dhalt = 1; tick(); dhalt = 0;
    total++; if (pc !== 32'h10 || st !== 2'b01) begin
      bad++; $display("FAIL st_halt pc=%h st=%b exp 10/01", pc, st); end
    stall = 1; dstep = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); dstep = 0;
      total++; if (pc !== 32'h10 || st !== 2'b10 || done !== 1'b0) begin
        bad++; $display("FAIL st_stall%0d pc=%h st=%b done=%b exp 10/10/0", i, pc, st, done); end
    end
    stall = 0; tick();
    total++; if (pc !== 32'h14 || st !== 2'b01 || done !== 1'b1) begin
      bad++; $display("FAIL st_done pc=%h st=%b done=%b exp 14/01/1", pc, st, done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL st_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_step_halts();
    dstep = 1; tick(); dstep = 0;
    ihalt = 1; tick(); ihalt = 0;
    total++; if (pc !== 32'h14 || st !== 2'b01 || done !== 1'b1) begin
      bad++; $display("FAIL sh_instr pc=%h st=%b done=%b exp 14/01/1", pc, st, done); end
    dstep = 1; tick(); dstep = 0;
    dhalt = 1; tick(); dhalt = 0;
    total++; if (pc !== 32'h14 || st !== 2'b01 || done !== 1'b0) begin
      bad++; $display("FAIL sh_dbg pc=%h st=%b done=%b exp 14/01/0", pc, st, done); end
    // run and step together: step wins
    drun = 1; dstep = 1; stall = 1; tick(); drun = 0; dstep = 0;
    total++; if (st !== 2'b10) begin bad++; $display("FAIL sh_prio st=%b exp=10", st); end
    idle(); tick();
  endtask

  task automatic test_wrap();
    rst8 = 1; tick(); rst8 = 0;
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] e;
      tick();
      e = 8'hF4 + 8'(4 * k);
      total++; if (pc8 !== e) begin bad++; $display("FAIL wrap%0d got=%h exp=%h", k, pc8, e); end
    end
  endtask

  task automatic test_rst_step();
    wen = 1; widx = 1; waddr = 32'h08; wvalid = 1; tick(); idle();
    stall = 1; dstep = 1; tick(); dstep = 0;
    rst = 1; tick(); rst = 0;
    total++; if (pc !== 32'h0 || st !== 2'b01 || done !== 1'b0) begin
      bad++; $display("FAIL rs_state pc=%h st=%b done=%b exp 0/01/0", pc, st, done); end
    stall = 0; tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rs_nopulse got=%b exp=0", done); end
    drun = 1; tick(); drun = 0;
    repeat (4) tick();
    total++; if (pc !== 32'h10 || st !== 2'b00 || hit !== 1'b0) begin
      bad++; $display("FAIL rs_bkclr pc=%h st=%b hit=%b exp 10/00/0", pc, st, hit); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom % 200) == 0;
      stall    = ($urandom % 4) == 0;
      exc      = ($urandom % 16) == 0;
      br       = ($urandom % 6) == 0;
      jmp      = ($urandom % 8) == 0;
      exc_vec  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      br_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      jmp_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      ihalt    = ($urandom % 20) == 0;
      dhalt    = ($urandom % 20) == 0;
      drun     = ($urandom % 3) == 0;
      dstep    = ($urandom % 6) == 0;
      wen      = ($urandom % 6) == 0;
      widx     = 2'($urandom % 4);
      waddr    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      wvalid   = 1'($urandom);
      tick();
      total++;
      if (pc !== m_pc || pc_seq !== m_pc + 32'd4 || st !== 2'(m_st) ||
          halted !== (m_st == MH) || hit !== m_hit || done !== m_done ||
          adv_cnt !== m_cnt) begin
        bad++;
        $display("FAIL rand c=%0d pc=%h/%h st=%b/%0d hlt=%b hit=%b/%b done=%b/%b cnt=%0d/%0d",
                 c, pc, m_pc, st, m_st, halted, hit, m_hit, done, m_done, adv_cnt, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst8 = 1;
    test_reset();
    test_run_free();
    test_priority();
    test_bkpt();
    test_step_stall();
    test_step_halts();
    test_wrap();
    test_rst_step();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_debug_unit.md
Name: pc_debug_unit

Overview:
- Parametrised next-generation program counter for the pipelined MIPS fetch stage, with built-in debug control.
- Selects the next PC from a prioritised set of redirect sources: exception, branch, jump, or sequential increment.
- Honours pipeline stalls.
- Adds a RUN/HALTED/STEP execution state machine, programmable address breakpoints and an advance counter, all driven by the UART debug unit.

Parameters:
- NB_PC, 32, PC width in bits.
- RESET_ADDR, 0, PC value after reset.
- PC_INC, 4, sequential increment.
- N_BKPT, 4, number of breakpoint registers (1..16).
- START_HALTED, 1, 1 = leave reset in HALTED, 0 = leave reset in RUN.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_stall  in  1  hazard stall; PC holds while high.
- i_exc  in  1  exception redirect request.
- i_exc_vector  in  NB_PC  exception target.
- i_branch_taken  in  1  branch redirect request.
- i_branch_addr  in  NB_PC  branch target.
- i_jump  in  1  jump redirect request.
- i_jump_addr  in  NB_PC  jump target.
- i_instr_halt  in  1  HALT instruction decoded at fetch.
- i_dbg_halt_req  in  1  debug halt request (single-cycle pulse).
- i_dbg_run_req  in  1  debug run request (pulse).
- i_dbg_step_req  in  1  debug single-step request (pulse).
- i_bkpt_wr_en  in  1  breakpoint register write strobe.
- i_bkpt_wr_idx  in  $clog2(N_BKPT) (min 1)  breakpoint index to write.
- i_bkpt_wr_addr  in  NB_PC  breakpoint address.
- i_bkpt_wr_valid  in  1  enable bit written with the address.
- o_pc  out  NB_PC  current PC (registered).
- o_pc_next_seq  out  NB_PC  o_pc + PC_INC (combinational).
- o_state  out  2  execution state: 00 RUN, 01 HALTED, 10 STEP.
- o_halted  out  1  high when o_state == HALTED.
- o_bkpt_hit  out  1  one-cycle pulse on breakpoint halt.
- o_step_done  out  1  one-cycle pulse when a step completes.
- o_adv_cnt  out  32  count of PC advances.

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_pc = RESET_ADDR.
  - State = HALTED if START_HALTED, else RUN.
  - All breakpoints invalid, addresses 0.
  - o_adv_cnt = 0; o_bkpt_hit = 0; o_step_done = 0.
  - The resume-skip flag is set.
  - Reset mid-STEP or mid-RUN aborts immediately; no pulse is emitted.
- adv = (state == RUN or STEP) && !i_stall && !hold.
  - hold = halt condition this cycle: i_dbg_halt_req, i_instr_halt, or breakpoint match (RUN only).
- When adv, o_pc <= next, with priority i_exc > i_branch_taken > i_jump > o_pc + PC_INC. o_adv_cnt increments by 1 and wraps at 2^32.
- When not adv, o_pc and o_adv_cnt hold. Redirect inputs are ignored; the upstream stage must hold them while i_stall or HALTED.
- All additions are mod 2^NB_PC, so wrap-around is silent.
- Breakpoint match = any valid entry whose address == o_pc, evaluated in RUN only.
  - Suppressed on the first RUN cycle after leaving HALTED (skip flag), so resuming at a breakpoint does not re-trigger.
  - The skip flag clears after that cycle.
- State RUN:
  - i_dbg_halt_req, i_instr_halt or match -> HALTED; PC holds.
  - o_bkpt_hit = 1 next cycle iff a match caused or accompanied the halt.
  - i_stall does not block a halt.
- State HALTED:
  - i_dbg_step_req -> STEP (step wins if run and step requests arrive together).
  - Else i_dbg_run_req -> RUN.
  - Both transitions set the skip flag.
  - i_dbg_halt_req is ignored.
- State STEP:
  - Breakpoints are not checked.
  - On the first cycle with !i_stall, PC advances once -> HALTED; o_step_done pulses the next cycle.
  - While stalled, remains in STEP.
  - i_instr_halt in STEP -> HALTED with no advance; o_step_done still pulses.
  - i_dbg_halt_req in STEP -> HALTED, no advance, no pulse.
- Breakpoint writes:
  - Accepted in any state; take effect from the next cycle.
  - An out-of-range index is ignored.
  - A write to the same entry being matched this cycle uses the old value.
- o_halted and o_state are registered.

Test Plan:
- Reset with START_HALTED=1 -> o_pc=0, o_state=01. Pulse run; 5 free cycles -> o_pc=0x14, o_adv_cnt=5.
- i_exc=1 (vector 0x80), i_branch_taken=1 (0x40), i_jump=1 (0x20) in the same RUN cycle -> o_pc=0x80. Repeat without exc -> 0x40. Stall high with a branch pending -> o_pc unchanged.
- Breakpoint 0 = 0x0C, valid, from RUN at 0 -> halts with o_pc=0x0C, o_bkpt_hit pulse. Run req -> next o_pc=0x10, no second hit.
- In HALTED at 0x10, step req while stall held 3 cycles -> o_state=10 throughout, o_pc=0x10. Stall drops -> o_pc=0x14, HALTED, o_step_done pulse.
- NB_PC=8, PC_INC=4, o_pc=0xFC in RUN -> next o_pc=0x00.
- Assert i_rst during STEP -> o_pc=RESET_ADDR, breakpoints invalid, no o_step_done pulse.
